qsys_led_pwm_pio: RTL and testbench

Parametrised Avalon-MM output PIO for LED banks. It is the successor to the fixed 8-bit LED PIO and keeps the same data register at offset 0. It adds:
- configurable width;
- atomic set/clear write ports;
- a global PWM brightness control with glitch-free duty update;
- optional per-channel blinking.

It sits on the Qsys interconnect as a slave and drives board LEDs directly.

---
 rtl/qsys_led_pio_pkg.sv | 15 +
 rtl/qsys_led_pwm_timebase.sv | 45 ++++
 rtl/qsys_led_pwm_pio.sv | 155 +++++++++++++++
 tb/tb_qsys_led_pwm_pio.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_led_pio_pkg.sv
// Shared register map and configuration-register width for the LED PWM PIO.
package qsys_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_SET          = 3'd1;
    localparam logic [2:0] ADDR_CLEAR        = 3'd2;
    localparam logic [2:0] ADDR_DUTY         = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE     = 3'd4;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd5;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd6;

    // Width of the PRESCALE and BLINK_PERIOD registers
    localparam int unsigned CFG_W = 16;

endpackage

// File: rtl/qsys_led_pwm_timebase.sv
// PWM timebase: prescaler producing tick, and the PWM counter with its
// period_end strobe. A restart strobe returns the prescaler to 0.
module qsys_led_pwm_timebase
    import qsys_led_pio_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CFG_W-1:0]    prescale_i,
    input  logic                restart_i,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                tick_o,
    output logic                period_end_o
);

    logic [CFG_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o       = (presc_q == prescale_i);
        period_end_o = tick_o && (cnt_q == '1);
        presc_d      = presc_q + CFG_W'(1);
        if (restart_i || tick_o) begin
            presc_d = '0;
        end
        cnt_d = cnt_q;
        if (tick_o) begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_cnt_o = cnt_q;

endmodule

// File: rtl/qsys_led_pwm_pio.sv
// Avalon-MM LED PIO with set/clear ports, global PWM brightness and optional
// per-channel blinking (enabled by defining QSYS_LED_PIO_BLINK_EN).
module qsys_led_pwm_pio
    import qsys_led_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       PWM_BITS    = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam int unsigned      DW        = PWM_BITS + 1;
    localparam logic [DW-1:0]    DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

    logic                wr_en;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [DW-1:0]       duty_sh_q, duty_sh_d;
    logic [DW-1:0]       duty_act_q, duty_act_d;
    logic [CFG_W-1:0]    prescale_q, prescale_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [WIDTH-1:0]    blink_gate;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                period_end;
    logic                pwm_on;
    logic                unused_tick;
    logic                unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign unused_wd = ^writedata;

    qsys_led_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .prescale_i   (prescale_q),
        .restart_i    (wr_en && (address == ADDR_PRESCALE)),
        .pwm_cnt_o    (pwm_cnt),
        .tick_o       (unused_tick),
        .period_end_o (period_end)
    );

    assign pwm_on = ({1'b0, pwm_cnt} < duty_act_q);

`ifdef QSYS_LED_PIO_BLINK_EN
    logic [WIDTH-1:0] blink_mask_q, blink_mask_d;
    logic [CFG_W-1:0] blink_period_q, blink_period_d;
    logic [CFG_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    always_comb begin
        blink_mask_d   = blink_mask_q;
        blink_period_d = blink_period_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        if (wr_en && (address == ADDR_BLINK_MASK)) begin
            blink_mask_d = writedata[WIDTH-1:0];
        end
        // A period write restarts the blink cycle and outranks a coincident period_end
        if (wr_en && (address == ADDR_BLINK_PERIOD)) begin
            blink_period_d = writedata[CFG_W-1:0];
            blink_cnt_d    = '0;
            blink_phase_d  = 1'b1;
        end else if (blink_period_q == '0) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (period_end) begin
            if (blink_cnt_q == blink_period_q - CFG_W'(1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CFG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_mask_q   <= '0;
            blink_period_q <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b1;
        end else begin
            blink_mask_q   <= blink_mask_d;
            blink_period_q <= blink_period_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
        end
    end

    assign blink_gate = ~blink_mask_q | {WIDTH{blink_phase_q}};
`else
    assign blink_gate = '1;
`endif

    always_comb begin
        data_d     = data_q;
        duty_sh_d  = duty_sh_q;
        prescale_d = prescale_q;
        // Active duty only changes at a period boundary, so no pulse is cut or stretched
        duty_act_d = period_end ? duty_sh_q : duty_act_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = writedata[WIDTH-1:0];
                ADDR_SET:      data_d     = data_q | writedata[WIDTH-1:0];
                ADDR_CLEAR:    data_d     = data_q & ~writedata[WIDTH-1:0];
                ADDR_DUTY:     duty_sh_d  = writedata[DW-1:0];
                ADDR_PRESCALE: prescale_d = writedata[CFG_W-1:0];
                default:       ;
            endcase
        end
        out_d = data_q & {WIDTH{pwm_on}} & blink_gate;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            duty_sh_q  <= DUTY_FULL;
            duty_act_q <= DUTY_FULL;
            prescale_q <= '0;
            out_q      <= '0;
        end else begin
            data_q     <= data_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            prescale_q <= prescale_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data_q);
            ADDR_DUTY:                       readdata = 32'(duty_sh_q);
            ADDR_PRESCALE:                   readdata = 32'(prescale_q);
`ifdef QSYS_LED_PIO_BLINK_EN
            ADDR_BLINK_MASK:                 readdata = 32'(blink_mask_q);
            ADDR_BLINK_PERIOD:               readdata = 32'(blink_period_q);
`endif
            default:                         readdata = '0;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_qsys_led_pwm_pio.sv
// Bench for qsys_led_pwm_pio: directed PWM/blink scenarios plus randomized
// register traffic checked against a time-based reference model.
module tb_qsys_led_pwm_pio;
    import qsys_led_pio_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned PB    = 8;
    localparam int unsigned PER   = 1 << PB;
    localparam logic [31:0] WMASK = 32'h0000_00FF;
    localparam logic [31:0] RV    = 32'h0000_00A5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    always #5 clk = ~clk;

    qsys_led_pwm_pio #(
        .WIDTH       (W),
        .PWM_BITS    (PB),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: state kept as plain counters of elapsed ticks and periods
    logic [31:0] m_data, m_duty_sh, m_duty_act, m_prescale, m_mask, m_bper, m_out;
    int unsigned m_psc, m_pwm, m_periods;
    bit          m_phase, m_pend;

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: return m_data;
            ADDR_DUTY:                       return m_duty_sh;
            ADDR_PRESCALE:                   return m_prescale;
`ifdef QSYS_LED_PIO_BLINK_EN
            ADDR_BLINK_MASK:                 return m_mask;
            ADDR_BLINK_PERIOD:               return m_bper;
`endif
            default:                         return 32'd0;
        endcase
    endfunction

    function automatic bit pend_next();
        return (m_psc == m_prescale) && (m_pwm == PER - 1);
    endfunction

    task automatic model_edge(input bit rst, input bit wr, input logic [2:0] a, input logic [31:0] wd);
        bit          tick;
        logic [31:0] gate;
        if (rst) begin
            m_data = RV; m_duty_sh = PER; m_duty_act = PER; m_prescale = 0;
            m_mask = 0; m_bper = 0; m_periods = 0; m_phase = 1'b1;
            m_psc = 0; m_pwm = 0; m_out = 0; m_pend = 1'b0;
            return;
        end
        gate  = m_phase ? WMASK : (~m_mask & WMASK);
        m_out = (m_pwm < m_duty_act) ? (m_data & gate) : 32'd0;
        tick   = (m_psc == m_prescale);
        m_pend = tick && (m_pwm == PER - 1);
        if (m_pend) m_duty_act = m_duty_sh;
        if (m_pend && m_bper != 0) begin
            m_periods++;
            if (m_periods == m_bper) begin
                m_periods = 0;
                m_phase   = !m_phase;
            end
        end
        if (tick) m_pwm = (m_pwm + 1) % PER;
        m_psc = tick ? 0 : m_psc + 1;
        if (wr) begin
            case (a)
                ADDR_DATA:     m_data = wd & WMASK;
                ADDR_SET:      m_data = (m_data | wd) & WMASK;
                ADDR_CLEAR:    m_data = m_data & ~wd & WMASK;
                ADDR_DUTY:     m_duty_sh = wd % (2 * PER);
                ADDR_PRESCALE: begin m_prescale = wd & 32'hFFFF; m_psc = 0; end
`ifdef QSYS_LED_PIO_BLINK_EN
                ADDR_BLINK_MASK:   m_mask = wd & WMASK;
                ADDR_BLINK_PERIOD: begin m_bper = wd & 32'hFFFF; m_periods = 0; m_phase = 1'b1; end
`endif
                default: ;
            endcase
        end
    endtask

    // One clock: drive, check readdata mid-cycle, clock, check out_port
    task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] wd);
        reset_n    = !rst;
        chipselect = wr | rd;
        write_n    = !wr;
        address    = a;
        writedata  = wd;
        #1;
        if (!rst) check_eq("readdata", readdata, model_read(a));
        @(posedge clk);
        model_edge(rst, wr, a, wd);
        #1;
        check_eq("out_port", 32'(out_port), m_out);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
        check_eq(tag, readdata, exp);
    endtask

    task automatic wait_pend(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            cyc(1'b0, 1'b0, 1'b1, ADDR_DATA, 32'd0);
            seen = m_pend;
        end
        check_eq("wait_pend", 32'(seen), 32'd1);
    endtask

    task automatic count_win(input int n, input int wr_at, input logic [2:0] wa, input logic [31:0] wd,
                             input logic [W-1:0] bm, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) cyc(1'b0, 1'b1, 1'b0, wa, wd);
            else            cyc(1'b0, 1'b0, 1'b1, ADDR_DATA, 32'd0);
            if ((out_port & bm) != '0) cnt++;
        end
    endtask

    initial begin
        int          cnt;
        logic [2:0]  a;
        logic [31:0] d;
        bit          w, r;

        // Reset with writes attempted during reset
        cyc(1'b1, 1'b1, 1'b0, ADDR_DATA, 32'hFF);
        cyc(1'b1, 1'b1, 1'b0, ADDR_DUTY, 32'h10);
        check_eq("rst_out", 32'(out_port), 32'h0);
        rd_chk("rst_duty", ADDR_DUTY, 32'd256);
        check_eq("rel_out", 32'(out_port), 32'hA5);
        rd_chk("rst_prescale", ADDR_PRESCALE, 32'd0);
        rd_chk("rst_data", ADDR_DATA, 32'hA5);

        // DATA / SET / CLEAR
        wr(ADDR_DATA, 32'hFFFF_FF0F);
        rd_chk("data_wr", ADDR_DATA, 32'h0F);
        check_eq("data_out", 32'(out_port), 32'h0F);
        wr(ADDR_SET, 32'hF0);
        rd_chk("set_rd", ADDR_SET, 32'hFF);
        check_eq("set_out", 32'(out_port), 32'hFF);
        wr(ADDR_SET, 32'h0);
        rd_chk("set_zero", ADDR_DATA, 32'hFF);
        wr(ADDR_CLEAR, 32'h3C);
        rd_chk("clear_rd", ADDR_CLEAR, 32'hC3);
        check_eq("clear_out", 32'(out_port), 32'hC3);
        wr(ADDR_CLEAR, 32'h0);
        rd_chk("clear_zero", ADDR_DATA, 32'hC3);
        rd_chk("addr7", 3'd7, 32'h0);

        // Steady duty 64 and duty 0
        wr(ADDR_DATA, 32'hFF);
        wr(ADDR_DUTY, 32'd64);
        rd_chk("duty_shadow", ADDR_DUTY, 32'd64);
        wait_pend(2 * PER);
        count_win(PER, -1, ADDR_DATA, 32'd0, 8'hFF, cnt);
        check_eq("duty64_cnt", 32'(cnt), 32'd64);
        wr(ADDR_DUTY, 32'd0);
        wait_pend(2 * PER);
        count_win(PER, -1, ADDR_DATA, 32'd0, 8'hFF, cnt);
        check_eq("duty0_cnt", 32'(cnt), 32'd0);

        // Mid-period duty write takes effect only at the next period boundary
        wr(ADDR_DUTY, 32'd64);
        wait_pend(2 * PER);
        count_win(PER, 10, ADDR_DUTY, 32'd128, 8'hFF, cnt);
        check_eq("mid_old_duty", 32'(cnt), 32'd64);
        count_win(PER, -1, ADDR_DATA, 32'd0, 8'hFF, cnt);
        check_eq("mid_new_duty", 32'(cnt), 32'd128);

        // Write on the period_end cycle is deferred one period
        for (int i = 0; i < 2 * PER && !pend_next(); i++) cyc(1'b0, 1'b0, 1'b1, ADDR_DATA, 32'd0);
        wr(ADDR_DUTY, 32'd32);
        check_eq("pend_write_seen", 32'(m_pend), 32'd1);
        count_win(PER, -1, ADDR_DATA, 32'd0, 8'hFF, cnt);
        check_eq("defer_old", 32'(cnt), 32'd128);
        count_win(PER, -1, ADDR_DATA, 32'd0, 8'hFF, cnt);
        check_eq("defer_new", 32'(cnt), 32'd32);

        // PRESCALE=3, including a mid-count restart
        wr(ADDR_PRESCALE, 32'hABCD_0003);
        rd_chk("prescale_rd", ADDR_PRESCALE, 32'h3);
        wr(ADDR_PRESCALE, 32'd3);
        wait_pend(3 * 4 * PER);
        count_win(4 * PER, -1, ADDR_DATA, 32'd0, 8'hFF, cnt);
        check_eq("presc3_cnt", 32'(cnt), 32'd128);
        check_eq("presc3_pend", 32'(m_pend), 32'd1);

        // Blink
        wr(ADDR_PRESCALE, 32'd0);
        wr(ADDR_DUTY, 32'd256);
        wait_pend(5 * PER);
        wait_pend(2 * PER);
        wr(ADDR_BLINK_MASK, 32'h01);
        wr(ADDR_BLINK_PERIOD, 32'd2);
`ifdef QSYS_LED_PIO_BLINK_EN
        rd_chk("bmask_rd", ADDR_BLINK_MASK, 32'h01);
        rd_chk("bper_rd", ADDR_BLINK_PERIOD, 32'h2);
        wait_pend(2 * PER);
        wr(ADDR_BLINK_PERIOD, 32'd2);
        count_win(8 * PER, -1, ADDR_DATA, 32'd0, 8'h01, cnt);
        check_eq("blink_bit0", 32'(cnt), 32'd1024);
`else
        rd_chk("bmask_rd", ADDR_BLINK_MASK, 32'h0);
        rd_chk("bper_rd", ADDR_BLINK_PERIOD, 32'h0);
        count_win(4 * PER, -1, ADDR_DATA, 32'd0, 8'h01, cnt);
        check_eq("noblink_bit0", 32'(cnt), 32'd1024);
`endif
        count_win(2 * PER, -1, ADDR_DATA, 32'd0, 8'hFE, cnt);
        check_eq("blink_others", 32'(cnt), 32'd512);

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 8000; i++) begin
            a = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 7) == 0);
            r = !w && ($urandom_range(0, 1) == 1);
            d = $urandom();
            if (a == ADDR_PRESCALE)     d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 2));
            if (a == ADDR_BLINK_PERIOD) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) cyc(1'b1, w, r, a, d);
            end else begin
                cyc(1'b0, w, r, a, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
